simmem_addr_arbiter: RTL and testbench

Admits at most one address request per cycle from the requester into the delay calculator, which models a single rank that can accept one command per cycle. It sits between the requester's write/read address channels and the delay calculator's `waddr`/`raddr` inputs. It forwards each granted request through a one-entry registered slot per channel. Reads have priority by default; a saturating starvation counter forces a write grant after `MaxStarvation` consecutive read wins. Write data is not routed through this block: holding back a write address is safe because the delay calculator already counts write data that arrives ahead of its address.

---
 rtl/simmem_pkg.sv | 26 ++
 rtl/simmem_addr_arbiter_if.sv | 29 ++
 rtl/simmem_addr_arbiter.sv | 154 +++++++++++++++
 tb/tb_simmem_addr_arbiter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/simmem_pkg.sv
// Shared address-channel types for the simulated memory controller.
// Address payloads carry the AXI fields the delay calculator needs; iids index the response banks.
package simmem_pkg;

    localparam int unsigned IdWidth      = 4;
    localparam int unsigned AddrWidth    = 32;
    localparam int unsigned LenWidth     = 8;
    localparam int unsigned WriteIidBits = 4;
    localparam int unsigned ReadIidBits  = 4;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [AddrWidth-1:0] addr;
        logic [LenWidth-1:0]  len;
    } waddr_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [AddrWidth-1:0] addr;
        logic [LenWidth-1:0]  len;
    } raddr_t;

    typedef logic [WriteIidBits-1:0] write_iid_t;
    typedef logic [ReadIidBits-1:0]  read_iid_t;

endpackage

// File: rtl/simmem_addr_arbiter_if.sv
// Write/read address channel bundle: payload, internal id and valid/ready per channel.
// The master drives payload/iid/valid and the slave answers with ready.
interface simmem_addr_arbiter_if;

    simmem_pkg::waddr_t     waddr;
    simmem_pkg::write_iid_t waddr_iid;
    logic                   waddr_valid;
    logic                   waddr_ready;

    simmem_pkg::raddr_t     raddr;
    simmem_pkg::read_iid_t  raddr_iid;
    logic                   raddr_valid;
    logic                   raddr_ready;

    modport master (
        output waddr, waddr_iid, waddr_valid,
        input  waddr_ready,
        output raddr, raddr_iid, raddr_valid,
        input  raddr_ready
    );

    modport slave (
        input  waddr, waddr_iid, waddr_valid,
        output waddr_ready,
        input  raddr, raddr_iid, raddr_valid,
        output raddr_ready
    );

endinterface

// File: rtl/simmem_addr_arbiter.sv
// Admits at most one address request per cycle into the delay calculator, read-first with
// a saturating starvation counter that forces a write grant after MaxStarvation read wins.
module simmem_addr_arbiter #(
    parameter int unsigned MaxStarvation = 32'd4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    simmem_addr_arbiter_if.slave  req_if,
    simmem_addr_arbiter_if.master dc_if
);

    localparam int unsigned StarvW = (MaxStarvation == 32'd0) ? 32'd1 : $clog2(MaxStarvation + 32'd1);
    localparam logic [StarvW-1:0] StarvMax = StarvW'(MaxStarvation);

    typedef enum logic [0:0] {
        READ_PRIO  = 1'b0,
        WRITE_PRIO = 1'b1
    } arb_state_e;

    // With a zero budget the write side owns priority from the very first cycle.
    localparam arb_state_e ResetState = (MaxStarvation == 32'd0) ? WRITE_PRIO : READ_PRIO;

    logic                   active_r;
    arb_state_e             state_r;
    logic [StarvW-1:0]      starv_r;

    logic                   w_valid_r;
    simmem_pkg::waddr_t     w_addr_r;
    simmem_pkg::write_iid_t w_iid_r;
    logic                   r_valid_r;
    simmem_pkg::raddr_t     r_addr_r;
    simmem_pkg::read_iid_t  r_iid_r;

    logic                   w_free_s;
    logic                   r_free_s;
    logic                   w_elig_s;
    logic                   r_elig_s;
    logic                   w_grant_s;
    logic                   r_grant_s;
    logic [StarvW-1:0]      starv_next_s;
    arb_state_e             state_next_s;

    // A slot is free when empty or draining this cycle; active_r holds ready low through reset.
    always_comb begin
        w_free_s = !w_valid_r || dc_if.waddr_ready;
        r_free_s = !r_valid_r || dc_if.raddr_ready;
        w_elig_s = active_r && req_if.waddr_valid && w_free_s;
        r_elig_s = active_r && req_if.raddr_valid && r_free_s;
    end

    // Single-grant arbitration: the priority state only matters when both channels compete.
    always_comb begin
        w_grant_s = 1'b0;
        r_grant_s = 1'b0;
        if (w_elig_s && r_elig_s) begin
            if (state_r == WRITE_PRIO) begin
                w_grant_s = 1'b1;
            end else begin
                r_grant_s = 1'b1;
            end
        end else if (w_elig_s) begin
            w_grant_s = 1'b1;
        end else if (r_elig_s) begin
            r_grant_s = 1'b1;
        end else begin
            w_grant_s = 1'b0;
            r_grant_s = 1'b0;
        end
    end

    // Starvation bookkeeping: only a contested read win counts; a write blocked by its own slot holds.
    always_comb begin
        starv_next_s = starv_r;
        if (w_elig_s && r_elig_s && r_grant_s) begin
            if (starv_r == StarvMax) begin
                starv_next_s = starv_r;
            end else begin
                starv_next_s = starv_r + StarvW'(1);
            end
        end else if (w_grant_s || !req_if.waddr_valid) begin
            starv_next_s = '0;
        end else begin
            starv_next_s = starv_r;
        end

        if (starv_next_s == StarvMax) begin
            state_next_s = WRITE_PRIO;
        end else begin
            state_next_s = READ_PRIO;
        end
    end

    // Arbitration FSM together with its starvation counter and the post-reset enable.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            active_r <= 1'b0;
            state_r  <= ResetState;
            starv_r  <= '0;
        end else begin
            active_r <= 1'b1;
            state_r  <= state_next_s;
            starv_r  <= starv_next_s;
        end
    end

    // Write slot: a grant refills it even while draining, otherwise a drain empties it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_valid_r <= 1'b0;
            w_addr_r  <= '0;
            w_iid_r   <= '0;
        end else begin
            if (w_grant_s) begin
                w_valid_r <= 1'b1;
                w_addr_r  <= req_if.waddr;
                w_iid_r   <= req_if.waddr_iid;
            end else if (w_valid_r && dc_if.waddr_ready) begin
                w_valid_r <= 1'b0;
            end else begin
                w_valid_r <= w_valid_r;
            end
        end
    end

    // Read slot: same refill-or-drain behaviour as the write slot.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid_r <= 1'b0;
            r_addr_r  <= '0;
            r_iid_r   <= '0;
        end else begin
            if (r_grant_s) begin
                r_valid_r <= 1'b1;
                r_addr_r  <= req_if.raddr;
                r_iid_r   <= req_if.raddr_iid;
            end else if (r_valid_r && dc_if.raddr_ready) begin
                r_valid_r <= 1'b0;
            end else begin
                r_valid_r <= r_valid_r;
            end
        end
    end

    assign req_if.waddr_ready = w_grant_s;
    assign req_if.raddr_ready = r_grant_s;

    assign dc_if.waddr       = w_addr_r;
    assign dc_if.waddr_iid   = w_iid_r;
    assign dc_if.waddr_valid = w_valid_r;
    assign dc_if.raddr       = r_addr_r;
    assign dc_if.raddr_iid   = r_iid_r;
    assign dc_if.raddr_valid = r_valid_r;

endmodule

// File: tb/tb_simmem_addr_arbiter.sv
// Randomized bench for simmem_addr_arbiter: two instances (budget 4 and budget 0) share stimulus
// and are compared every cycle against a per-instance reference model.
module tb_simmem_addr_arbiter;
    import simmem_pkg::*;

    localparam int WD = $bits(waddr_t) + $bits(write_iid_t);
    localparam int RD = $bits(raddr_t) + $bits(read_iid_t);

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    waddr_t     w_in;
    write_iid_t wiid_in;
    logic       wv_in;
    raddr_t     r_in;
    read_iid_t  riid_in;
    logic       rv_in;
    logic       wr_in;
    logic       rr_in;

    simmem_addr_arbiter_if req0();
    simmem_addr_arbiter_if req1();
    simmem_addr_arbiter_if dc0();
    simmem_addr_arbiter_if dc1();

    assign req0.waddr = w_in;  assign req0.waddr_iid = wiid_in; assign req0.waddr_valid = wv_in;
    assign req0.raddr = r_in;  assign req0.raddr_iid = riid_in; assign req0.raddr_valid = rv_in;
    assign req1.waddr = w_in;  assign req1.waddr_iid = wiid_in; assign req1.waddr_valid = wv_in;
    assign req1.raddr = r_in;  assign req1.raddr_iid = riid_in; assign req1.raddr_valid = rv_in;
    assign dc0.waddr_ready = wr_in; assign dc0.raddr_ready = rr_in;
    assign dc1.waddr_ready = wr_in; assign dc1.raddr_ready = rr_in;

    simmem_addr_arbiter #(.MaxStarvation(4)) dut0 (.clk_i(clk_i), .rst_ni(rst_ni), .req_if(req0), .dc_if(dc0));
    simmem_addr_arbiter #(.MaxStarvation(0)) dut1 (.clk_i(clk_i), .rst_ni(rst_ni), .req_if(req1), .dc_if(dc1));

    logic          o_wrdy[2], o_rrdy[2], o_wv[2], o_rv[2];
    logic [WD-1:0] o_wd[2];
    logic [RD-1:0] o_rd[2];
    assign o_wrdy[0] = req0.waddr_ready; assign o_rrdy[0] = req0.raddr_ready;
    assign o_wrdy[1] = req1.waddr_ready; assign o_rrdy[1] = req1.raddr_ready;
    assign o_wv[0] = dc0.waddr_valid; assign o_rv[0] = dc0.raddr_valid;
    assign o_wv[1] = dc1.waddr_valid; assign o_rv[1] = dc1.raddr_valid;
    assign o_wd[0] = {dc0.waddr, dc0.waddr_iid}; assign o_rd[0] = {dc0.raddr, dc0.raddr_iid};
    assign o_wd[1] = {dc1.waddr, dc1.waddr_iid}; assign o_rd[1] = {dc1.raddr, dc1.raddr_iid};

    // Reference model: per instance, the pending slot contents and the run of contested read wins.
    int            budget[2] = '{4, 0};
    logic          m_act[2];
    logic          m_wv[2], m_rv[2];
    logic [WD-1:0] m_wd[2];
    logic [RD-1:0] m_rd[2];
    int            losses[2];

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_act[k] = 1'b0;
            m_wv[k] = 1'b0;  m_rv[k] = 1'b0;
            m_wd[k] = '0;    m_rd[k] = '0;
            losses[k] = 0;
        end
    endtask

    task automatic drive(input int wvp, input int rvp, input int wrp, input int rrp);
        logic [63:0] r;
        logic [31:0] u;
        r = {$urandom(), $urandom()};
        w_in = waddr_t'(r[$bits(waddr_t)-1:0]);
        r = {$urandom(), $urandom()};
        r_in = raddr_t'(r[$bits(raddr_t)-1:0]);
        u = $urandom();
        wiid_in = u[3:0];
        riid_in = u[7:4];
        wv_in = ($urandom_range(99) < wvp);
        rv_in = ($urandom_range(99) < rvp);
        wr_in = ($urandom_range(99) < wrp);
        rr_in = ($urandom_range(99) < rrp);
    endtask

    // Compares both instances with the model, then advances the model across the coming edge.
    task automatic check_and_step();
        logic we, re, wg, rg;
        for (int k = 0; k < 2; k++) begin
            we = m_act[k] && wv_in && (!m_wv[k] || wr_in);
            re = m_act[k] && rv_in && (!m_rv[k] || rr_in);
            if (we && re) begin
                wg = (losses[k] >= budget[k]);
                rg = !wg;
            end else begin
                wg = we;
                rg = re;
            end
            check_val($sformatf("wready%0d", k), o_wrdy[k], wg);
            check_val($sformatf("rready%0d", k), o_rrdy[k], rg);
            check_val($sformatf("wvalid%0d", k), o_wv[k], m_wv[k]);
            check_val($sformatf("rvalid%0d", k), o_rv[k], m_rv[k]);
            if (m_wv[k]) check_val($sformatf("wdata%0d", k), o_wd[k], m_wd[k]);
            if (m_rv[k]) check_val($sformatf("rdata%0d", k), o_rd[k], m_rd[k]);
            if (rst_ni) begin
                if (we && re && rg) losses[k] = (losses[k] + 1 > budget[k]) ? budget[k] : losses[k] + 1;
                else if (wg || !wv_in) losses[k] = 0;
                if (wg) begin
                    m_wv[k] = 1'b1;
                    m_wd[k] = {w_in, wiid_in};
                end else if (wr_in) begin
                    m_wv[k] = 1'b0;
                end
                if (rg) begin
                    m_rv[k] = 1'b1;
                    m_rd[k] = {r_in, riid_in};
                end else if (rr_in) begin
                    m_rv[k] = 1'b0;
                end
                m_act[k] = 1'b1;
            end
        end
    endtask

    task automatic run(input int n, input int wvp, input int rvp, input int wrp, input int rrp);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i);
            drive(wvp, rvp, wrp, rrp);
            #1;
            check_and_step();
        end
    endtask

    initial begin
        model_reset();
        drive(100, 100, 100, 100);

        // Reset held with both requests pending: nothing may be granted or presented.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            #1;
            check_and_step();
            check_val("rst_wdata0", o_wd[0], '0);
            check_val("rst_rdata1", o_rd[1], '0);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        check_and_step();

        // Saturated traffic: budget 4 grants W on every fifth cycle, budget 0 always grants W.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            drive(100, 100, 100, 100);
            #1;
            check_val("seq_w0", o_wrdy[0], (i % 5) == 4);
            check_val("seq_r0", o_rrdy[0], (i % 5) != 4);
            check_val("seq_w1", o_wrdy[1], 1'b1);
            check_and_step();
        end

        run(8, 100, 0, 100, 100);    // write-only burst
        run(3, 0, 0, 100, 100);
        run(5, 100, 100, 100, 0);    // read side stalled
        run(4, 100, 100, 100, 100);
        run(8, 100, 100, 0, 100);    // write side stalled
        run(4, 100, 100, 100, 100);
        run(400, 70, 70, 60, 60);

        // Asynchronous reset in the middle of a cycle drops the slots immediately.
        @(negedge clk_i);
        #3;
        rst_ni = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check_val($sformatf("mid_rst_wv%0d", k), o_wv[k], 1'b0);
            check_val($sformatf("mid_rst_rv%0d", k), o_rv[k], 1'b0);
            check_val($sformatf("mid_rst_wrdy%0d", k), o_wrdy[k], 1'b0);
        end
        model_reset();
        run(2, 100, 100, 100, 100);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        check_and_step();
        run(300, 80, 80, 50, 50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
